// File: rtl/sa_1d_stream.sv
// Transposed-form systolic 1-D FIR: NUM_PE taps, streamed samples, two-cycle result latency.
// Optional macro SA_SAT_EN: clamp results to PSUM_WIDTH and report clamping on sat_flag.
module sa_1d_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PE     = 3,
  parameter int unsigned PSUM_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic                         w_valid,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic                         start,
  input  logic [15:0]                  frame_len,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         in_ready,
  output logic                         valid_out,
  output logic signed [PSUM_WIDTH-1:0] psum_out,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag
);

  localparam int unsigned AW = 2 * DATA_WIDTH + $clog2(NUM_PE);
  localparam int unsigned IW = $clog2(NUM_PE);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e                        r_state, w_state_d;
  logic signed [DATA_WIDTH-1:0]  r_w [NUM_PE];
  logic [IW-1:0]                 r_widx;
  logic                          r_loaded;
  logic [15:0]                   r_cnt, r_len;
  logic                          r_dcnt;
  logic signed [AW-1:0]          r_p [NUM_PE];
  logic signed [AW-1:0]          w_prod [NUM_PE];
  logic                          r_v1, r_valid;
  logic signed [PSUM_WIDTH-1:0]  r_psum, w_res;
  logic                          w_load_go, w_start_go, w_acc, w_last_w, w_last_x, w_warm;

  assign w_load_go  = (r_state == StIdle) && load_start;
  assign w_start_go = (r_state == StIdle) && !load_start && start && r_loaded;
  assign in_ready   = (r_state == StRun) && (r_cnt != r_len);
  assign w_acc      = valid_in && in_ready;
  assign w_last_w   = (r_state == StLoad) && w_valid && (r_widx == IW'(NUM_PE - 1));
  assign w_last_x   = w_acc && (({1'b0, r_cnt} + 17'd1) == {1'b0, r_len});
  // r_cnt is the index n of the sample being accepted
  assign w_warm     = r_cnt >= 16'(NUM_PE - 1);

  always_comb begin
    for (int k = 0; k < NUM_PE; k++) begin
      w_prod[k] = AW'(r_w[k]) * AW'(data_in);
    end
  end

`ifdef SA_SAT_EN
  localparam int unsigned EW = (AW > PSUM_WIDTH) ? AW : PSUM_WIDTH;
  localparam logic signed [EW-1:0] SMAX = {{(EW - PSUM_WIDTH + 1){1'b0}}, {(PSUM_WIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW - PSUM_WIDTH + 1){1'b1}}, {(PSUM_WIDTH - 1){1'b0}}};
  logic signed [EW-1:0] w_ext;
  logic                 w_clip;
  logic                 r_sat;

  always_comb begin
    w_ext  = EW'(r_p[0]);
    w_clip = 1'b0;
    w_res  = w_ext[PSUM_WIDTH-1:0];
    if (w_ext > SMAX) begin
      w_clip = 1'b1;
      w_res  = SMAX[PSUM_WIDTH-1:0];
    end else if (w_ext < SMIN) begin
      w_clip = 1'b1;
      w_res  = SMIN[PSUM_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_start_go) begin
      r_sat <= 1'b0;
    end else if (r_v1 && w_clip) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_res    = PSUM_WIDTH'(r_p[0]);
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_load_go) begin
          w_state_d = StLoad;
        end else if (w_start_go) begin
          w_state_d = StRun;
        end
      end
      StLoad:  if (w_last_w) w_state_d = StIdle;
      StRun:   if ((r_cnt == r_len) || w_last_x) w_state_d = StDrain;
      StDrain: if (r_dcnt) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PE; k++) begin
        r_w[k] <= '0;
        r_p[k] <= '0;
      end
      r_widx   <= '0;
      r_loaded <= 1'b0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_dcnt   <= 1'b0;
      r_v1     <= 1'b0;
      r_valid  <= 1'b0;
      r_psum   <= '0;
    end else begin
      if (w_load_go) begin
        r_widx <= '0;
      end else if ((r_state == StLoad) && w_valid) begin
        r_w[r_widx] <= w_data;
        r_widx      <= r_widx + IW'(1);
      end
      if (w_last_w) begin
        r_loaded <= 1'b1;
      end
      if (w_start_go) begin
        r_cnt <= '0;
        r_len <= frame_len;
        for (int k = 0; k < NUM_PE; k++) begin
          r_p[k] <= '0;
        end
      end else if (w_acc) begin
        r_cnt <= r_cnt + 16'd1;
        r_p[NUM_PE-1] <= w_prod[NUM_PE-1];
        for (int k = 0; k < NUM_PE - 1; k++) begin
          r_p[k] <= r_p[k+1] + w_prod[k];
        end
      end
      r_dcnt  <= (r_state == StDrain) && !r_dcnt;
      r_v1    <= w_acc && w_warm;
      r_valid <= r_v1;
      if (r_v1) begin
        r_psum <= w_res;
      end
    end
  end

  assign valid_out = r_valid;
  assign psum_out  = r_psum;
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDrain) && r_dcnt;

endmodule

// File: tb/tb_sa_1d_stream.sv
// Bench for sa_1d_stream: directed vector table, reset/ignore corner cases, random frames
// checked against a convolution model computed directly from the sample history.
module tb_sa_1d_stream;
  localparam int DW = 8;
  localparam int NP = 3;
  localparam int PW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 load_start = 1'b0, w_valid = 1'b0, start = 1'b0, valid_in = 1'b0;
  logic signed [DW-1:0] w_data = '0, data_in = '0;
  logic [15:0]          frame_len = '0;
  logic                 in_ready, valid_out, busy, done, sat_flag;
  logic signed [PW-1:0] psum_out;

  always #5 clk = ~clk;

  sa_1d_stream #(.DATA_WIDTH(DW), .NUM_PE(NP), .PSUM_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .w_valid(w_valid), .w_data(w_data),
    .start(start), .frame_len(frame_len), .valid_in(valid_in), .data_in(data_in),
    .in_ready(in_ready), .valid_out(valid_out), .psum_out(psum_out), .busy(busy),
    .done(done), .sat_flag(sat_flag)
  );

  typedef struct { int val; int at; } res_t;
  typedef struct {
    bit reload; logic [2:0][31:0] w; int len; logic [4:0][31:0] x;
    int gmax; int ny; logic [2:0][31:0] y; bit sat;
  } vec_t;

  int    checks = 0, errors = 0, cyc = 0;
  res_t  exp_q[$];
  int    got_q[$];
  int    m_hist[$];
  int    m_w[NP];
  bit    m_sat;
  int    m_last;
  int    last_acc, done_cnt = 0, done_at = 0;
  vec_t  tv[$];
  longint mon_s;
  bit    mon_st;
  res_t  mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int conv(longint s, output bit sat);
`ifdef SA_SAT_EN
    sat = 1'b1;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    sat = 1'b0;
    return int'(s);
`else
    logic signed [PW-1:0] t;
    t = s[PW-1:0];
    sat = 1'b0;
    return int'(t);
`endif
  endfunction

  // Reference model: y[n] = sum_k w[k]*x[n-k], emitted two cycles after x[n] is taken
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_in && in_ready) begin
        m_hist.push_back(int'(data_in));
        last_acc = cyc;
        if (m_hist.size() >= NP) begin
          mon_s = 0;
          for (int k = 0; k < NP; k++)
            mon_s += longint'(m_w[k]) * longint'(m_hist[m_hist.size() - 1 - k]);
          mon_e.val = conv(mon_s, mon_st);
          mon_e.at  = cyc + 2;
          if (mon_st) m_sat = 1'b1;
          m_last = mon_e.val;
          exp_q.push_back(mon_e);
        end
      end
      if (valid_out) begin
        got_q.push_back(int'(psum_out));
        if (exp_q.size() == 0) chk("valid_out_unexpected", int'(valid_out), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("psum_out", int'(psum_out), mon_e.val);
          chk("valid_out_cycle", cyc, mon_e.at);
        end
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int a, int b, int c, bit with_start);
    int ws[NP];
    ws = '{a, b, c};
    load_start = 1'b1;
    start      = with_start;
    step();
    load_start = 1'b0;
    start      = 1'b0;
    chk("busy_in_load", int'(busy), 1);
    chk("in_ready_in_load", int'(in_ready), 0);
    for (int k = 0; k < NP; k++) begin
      repeat ($urandom_range(0, 1)) step();
      w_valid = 1'b1;
      w_data  = DW'(ws[k]);
      step();
      w_valid = 1'b0;
      m_w[k]  = ws[k];
    end
    chk("busy_after_load", int'(busy), 0);
  endtask

  task automatic send(int x, int g);
    int b;
    repeat (g) step();
    valid_in = 1'b1;
    data_in  = DW'(x);
    b = 0;
    while (!in_ready && b < 50) begin
      step();
      b++;
    end
    if (b == 50) chk("in_ready_timeout", int'(in_ready), 1);
    step();
    valid_in = 1'b0;
  endtask

  task automatic pulse_start(int len);
    exp_q.delete();
    m_hist.delete();
    got_q.delete();
    m_sat     = 1'b0;
    frame_len = 16'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_frame(int len, int xs[$], int gmax);
    int d0, sc, b;
    d0 = done_cnt;
    pulse_start(len);
    sc = cyc;
    for (int i = 0; i < len; i++) send(xs[i], (gmax == 0) ? 0 : $urandom_range(1, gmax));
    b = 0;
    while (done_cnt == d0 && b < 50) begin
      step();
      b++;
    end
    chk("done_count", done_cnt - d0, 1);
    chk("done_cycle", done_at, (len == 0) ? sc + 2 : last_acc + 2);
    step();
    chk("done_pulse_width", int'(done), 0);
    chk("results_pending", exp_q.size(), 0);
    chk("sat_flag", int'(sat_flag), int'(m_sat));
    chk("busy_after_frame", int'(busy), 0);
    if (len >= NP) chk("psum_hold", int'(psum_out), m_last);
  endtask

  function automatic void add_vec(bit rl, int w0, int w1, int w2, int len, int x0, int x1,
                                  int x2, int x3, int x4, int gmax, int ny, int y0, int y1,
                                  int y2, bit sat);
    vec_t v;
    v.reload = rl;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.len  = len;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3; v.x[4] = x4;
    v.gmax = gmax; v.ny = ny;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2;
    v.sat  = sat;
    tv.push_back(v);
  endfunction

  initial begin
    int xs[$];
    int d0;
    add_vec(1, 1, 2, 3, 4, 1, 2, 3, 4, 0, 0, 2, 10, 16, 0, 0);
    add_vec(0, 1, 2, 3, 4, 1, 2, 3, 4, 0, 3, 2, 10, 16, 0, 0);
    add_vec(1, -1, 2, -3, 5, 5, -4, 3, -2, 1, 1, 3, -26, 20, -14, 0);
`ifdef SA_SAT_EN
    add_vec(1, 127, 127, 127, 3, 127, 127, 127, 0, 0, 0, 1, 32767, 0, 0, 1);
    add_vec(1, -128, -128, -128, 3, 127, 127, 127, 0, 0, 2, 1, -32768, 0, 0, 1);
`else
    add_vec(1, 127, 127, 127, 3, 127, 127, 127, 0, 0, 0, 1, -17149, 0, 0, 0);
    add_vec(1, -128, -128, -128, 3, 127, 127, 127, 0, 0, 2, 1, 16768, 0, 0, 0);
`endif
    add_vec(1, 1, 2, 3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_psum_out", int'(psum_out), 0);
    step();
    rst_n = 1'b1;
    step();

    // start without any weights loaded is ignored
    pulse_start(4);
    repeat (5) begin
      chk("noload_in_ready", int'(in_ready), 0);
      chk("noload_busy", int'(busy), 0);
      step();
    end
    chk("noload_done", done_cnt, 0);

    foreach (tv[i]) begin
      if (tv[i].reload)
        do_load($signed(tv[i].w[0]), $signed(tv[i].w[1]), $signed(tv[i].w[2]), 1'b0);
      xs.delete();
      for (int j = 0; j < tv[i].len; j++) xs.push_back($signed(tv[i].x[j]));
      run_frame(tv[i].len, xs, tv[i].gmax);
      chk($sformatf("vec%0d_count", i), got_q.size(), tv[i].ny);
      for (int j = 0; j < tv[i].ny && j < got_q.size(); j++)
        chk($sformatf("vec%0d_y%0d", i, j), got_q[j], $signed(tv[i].y[j]));
      chk($sformatf("vec%0d_sat", i), int'(sat_flag), int'(tv[i].sat));
    end

    // load_start and start together: load wins
    do_load(2, -1, 1, 1'b1);
    xs = '{3, 1, 4, 1};
    run_frame(4, xs, 0);

    for (int it = 0; it < 25; it++) begin
      int len;
      if ($urandom_range(0, 3) == 0)
        do_load($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                $urandom_range(0, 255) - 128, 1'b0);
      len = $urandom_range(0, 8);
      xs.delete();
      for (int j = 0; j < len; j++) xs.push_back($urandom_range(0, 255) - 128);
      run_frame(len, xs, $urandom_range(0, 3));
    end

    // reset mid-run abandons the frame and the weights
    do_load(1, 2, 3, 1'b0);
    d0 = done_cnt;
    pulse_start(4);
    send(1, 0);
    send(2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_valid_out", int'(valid_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sat_flag", int'(sat_flag), 0);
    chk("midrst_psum_out", int'(psum_out), 0);
    step();
    rst_n = 1'b1;
    step();
    pulse_start(4);
    repeat (5) begin
      chk("postrst_in_ready", int'(in_ready), 0);
      chk("postrst_busy", int'(busy), 0);
      step();
    end
    chk("postrst_no_done", done_cnt - d0, 0);
    do_load(1, 2, 3, 1'b0);
    xs = '{1, 2, 3, 4};
    run_frame(4, xs, 2);
    chk("recover_count", got_q.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
